// File: rtl/writer_arb.sv
// Round-robin arbiter sharing one registered writer input stage between NREQ
// burst requesters; a grant lasts until req_last or BURST words.
module writer_arb #(
  parameter int DWIDTH = 10,
  parameter int NREQ   = 4,
  parameter int SWIDTH = 2,
  parameter int BURST  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req_vld,
  input  logic [NREQ*DWIDTH-1:0] req_data,
  input  logic [NREQ-1:0]        req_last,
  output logic [NREQ-1:0]        req_rdy,
  output logic                   wr_vld,
  output logic [DWIDTH-1:0]      wr_data,
  output logic [SWIDTH-1:0]      wr_src,
  output logic                   wr_last,
  input  logic                   wr_rdy,
  output logic                   busy
);

  localparam int CWIDTH = $clog2(BURST + 1);

  typedef enum logic {IDLE, XFER} state_t;

  state_t              r_state, w_state_nxt;
  logic [SWIDTH-1:0]   r_ptr, w_ptr_nxt;
  logic [SWIDTH-1:0]   r_gnt, w_gnt_nxt;
  logic [CWIDTH-1:0]   r_cnt, w_cnt_nxt;
  logic [SWIDTH-1:0]   w_pick, w_idx;
  logic                w_any, w_slot_ok, w_acc, w_last;

  logic                r_wr_vld, r_wr_last;
  logic [DWIDTH-1:0]   r_wr_data;
  logic [SWIDTH-1:0]   r_wr_src;

  // First requesting index at or after r_ptr, wrapping modulo NREQ.
  always_comb begin
    w_pick = r_ptr;
    w_any  = 1'b0;
    w_idx  = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      w_idx = SWIDTH'((32'(r_ptr) + k) % NREQ);
      if (!w_any && req_vld[w_idx]) begin
        w_any  = 1'b1;
        w_pick = w_idx;
      end
    end
  end

  assign w_slot_ok = (r_state == XFER) && (!r_wr_vld || wr_rdy);
  assign req_rdy   = w_slot_ok ? (NREQ'(1) << r_gnt) : '0;
  assign w_acc     = w_slot_ok && req_vld[r_gnt];
  assign w_last    = req_last[r_gnt] || (r_cnt == CWIDTH'(BURST - 1));

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_gnt_nxt   = r_gnt;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      IDLE: begin
        if (w_any) begin
          w_state_nxt = XFER;
          w_gnt_nxt   = w_pick;
          w_cnt_nxt   = '0;
        end
      end
      XFER: begin
        if (w_acc) begin
          w_cnt_nxt = r_cnt + CWIDTH'(1);
          if (w_last) begin
            w_state_nxt = IDLE;
            w_ptr_nxt   = (r_gnt == SWIDTH'(NREQ - 1)) ? '0 : r_gnt + SWIDTH'(1);
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_gnt   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_gnt   <= w_gnt_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Output stage: load on accept, drop valid once drained, otherwise hold.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_vld  <= 1'b0;
      r_wr_data <= '0;
      r_wr_src  <= '0;
      r_wr_last <= 1'b0;
    end else if (w_acc) begin
      r_wr_vld  <= 1'b1;
      r_wr_data <= req_data[r_gnt*DWIDTH +: DWIDTH];
      r_wr_src  <= r_gnt;
      r_wr_last <= w_last;
    end else if (wr_rdy) begin
      r_wr_vld  <= 1'b0;
    end
  end

  assign wr_vld  = r_wr_vld;
  assign wr_data = r_wr_data;
  assign wr_src  = r_wr_src;
  assign wr_last = r_wr_last;
  assign busy    = (r_state == XFER);

endmodule

// File: tb/tb_writer_arb.sv
// Bench for writer_arb: per-requester word queues drive the DUT, a cycle model
// built from the grant/burst rules predicts every output each cycle.
module tb_writer_arb;
  localparam int DW = 10;
  localparam int NR = 4;
  localparam int SW = 2;
  localparam int BU = 4;
  localparam int VW = 1 + NR + 1 + SW + 1 + DW;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [NR-1:0]    req_vld = '0, req_last = '0, req_rdy;
  logic [NR*DW-1:0] req_data = '0;
  logic             wr_vld, wr_last, busy;
  logic             wr_rdy = 1'b1;
  logic [DW-1:0]    wr_data;
  logic [SW-1:0]    wr_src;

  always #5 clk = ~clk;

  writer_arb #(.DWIDTH(DW), .NREQ(NR), .SWIDTH(SW), .BURST(BU)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_data(req_data),
    .req_last(req_last), .req_rdy(req_rdy), .wr_vld(wr_vld),
    .wr_data(wr_data), .wr_src(wr_src), .wr_last(wr_last),
    .wr_rdy(wr_rdy), .busy(busy)
  );

  int total = 0;
  int bad   = 0;

  logic [DW:0]   sq [NR][$];
  logic [NR-1:0] gap = '0;
  logic          rst_drv = 1'b1;
  logic          rdy_drv = 1'b1;

  logic          m_busy, m_vld, m_last;
  int            m_g, m_ptr, m_cnt, m_src;
  logic [DW-1:0] m_data;

  logic [VW-1:0] act_vec, exp_vec;
  logic          a_busy, a_vld, a_last, a_beat;
  logic [NR-1:0] a_reqrdy;
  logic [SW-1:0] a_src;
  logic [DW-1:0] a_data;
  int            cyc, s_cyc;

  task automatic m_reset();
    m_busy = 0; m_vld = 0; m_last = 0;
    m_g = 0; m_ptr = 0; m_cnt = 0; m_src = 0; m_data = '0;
  endtask

  task automatic clear_queues();
    for (int i = 0; i < NR; i++) sq[i].delete();
    gap = '0;
  endtask

  // Drive at negedge, sample 1ns later, then advance the model on posedge.
  task automatic step();
    logic [NR-1:0] erdy;
    logic [DW:0]   hd;
    logic          acc, was_busy, found;
    int            j;
    @(negedge clk);
    rst    = rst_drv;
    wr_rdy = rdy_drv;
    for (int i = 0; i < NR; i++) begin
      if (sq[i].size() > 0 && !gap[i]) begin
        req_vld[i] = 1'b1;
        req_data[i*DW +: DW] = sq[i][0][DW-1:0];
        req_last[i] = sq[i][0][DW];
      end else begin
        req_vld[i] = 1'b0;
        req_data[i*DW +: DW] = DW'($urandom);
        req_last[i] = 1'($urandom);
      end
    end
    #1;
    if (rst) m_reset();
    erdy = (m_busy && (!m_vld || wr_rdy)) ? (NR'(1) << m_g) : '0;
    exp_vec = {m_busy, erdy, m_vld, SW'(m_src), m_last, m_data};
    act_vec = {busy, req_rdy, wr_vld, wr_src, wr_last, wr_data};
    a_busy = busy; a_reqrdy = req_rdy; a_vld = wr_vld; a_src = wr_src;
    a_last = wr_last; a_data = wr_data; a_beat = wr_vld && wr_rdy;
    s_cyc = cyc;
    @(posedge clk);
    if (!rst) begin
      was_busy = m_busy;
      acc = m_busy && req_vld[m_g] && erdy[m_g];
      if (acc) begin
        hd = sq[m_g].pop_front();
        m_data = hd[DW-1:0];
        m_src  = m_g;
        m_last = hd[DW] || (m_cnt == BU - 1);
        m_vld  = 1;
        m_cnt++;
        if (m_last) begin
          m_busy = 0;
          m_ptr  = (m_g + 1) % NR;
        end
      end else if (wr_rdy) begin
        m_vld = 0;
      end
      if (!was_busy) begin
        found = 0;
        for (int k = 0; k < NR; k++) begin
          j = (m_ptr + k) % NR;
          if (!found && req_vld[j]) begin
            found = 1; m_g = j; m_cnt = 0; m_busy = 1;
          end
        end
      end
    end
    cyc++;
  endtask

  task automatic do_reset();
    clear_queues();
    rdy_drv = 1'b1;
    rst_drv = 1'b1;
    step();
    rst_drv = 1'b0;
    step();
    cyc = 0;
  endtask

  task automatic test_reset();
    clear_queues();
    rst_drv = 1'b1;
    rdy_drv = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (act_vec !== '0) begin
        bad++;
        $display("FAIL reset_zero got=%h want=0", act_vec);
      end
    end
    rst_drv = 1'b0;
    step();
    total++;
    if (act_vec !== exp_vec) begin
      bad++;
      $display("FAIL reset_release got=%h want=%h", act_vec, exp_vec);
    end
  endtask

  task automatic test_single();
    logic got3;
    do_reset();
    sq[2].push_back({1'b0, 10'h001});
    sq[2].push_back({1'b0, 10'h002});
    sq[2].push_back({1'b1, 10'h003});
    for (int c = 0; c < 8; c++) begin
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL single_model cyc=%0d got=%h want=%h", s_cyc, act_vec, exp_vec);
      end
      if (s_cyc == 1) begin
        total++;
        if (a_reqrdy !== 4'b0100) begin
          bad++;
          $display("FAIL single_grant got=%b want=0100", a_reqrdy);
        end
      end
      if (s_cyc >= 2 && s_cyc <= 4) begin
        total++;
        if ({a_vld, a_src, a_last, a_data} !== {1'b1, 2'd2, s_cyc == 4, DW'(s_cyc - 1)}) begin
          bad++;
          $display("FAIL single_word cyc=%0d got=%b/%0d/%b/%h want=1/2/%b/%h",
                   s_cyc, a_vld, a_src, a_last, a_data, s_cyc == 4, s_cyc - 1);
        end
      end
    end
    // ptr should now sit at 3, so 3 beats 0 when both request together
    sq[0].push_back({1'b1, 10'h0a0});
    sq[3].push_back({1'b1, 10'h3a0});
    got3 = 0;
    for (int c = 0; c < 10 && !got3; c++) begin
      step();
      if (a_beat) begin
        got3 = 1;
        total++;
        if (a_src !== 2'd3) begin
          bad++;
          $display("FAIL single_ptr got src=%0d want=3", a_src);
        end
      end
    end
    if (!got3) begin
      total++; bad++;
      $display("FAIL single_ptr got no beat want src=3");
    end
  endtask

  task automatic test_fairness();
    int n;
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int w = 0; w < 6; w++)
        sq[i].push_back({1'(w % 2), DW'(i * 64 + w)});
    n = 0;
    for (int c = 0; c < 45; c++) begin
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL fair_model cyc=%0d got=%h want=%h", s_cyc, act_vec, exp_vec);
      end
      if (a_beat) begin
        if (n < 10) begin
          total++;
          if (a_src !== SW'((n / 2) % NR) || s_cyc != 2 + (n / 2) * 3 + n % 2) begin
            bad++;
            $display("FAIL fair_order beat=%0d got src=%0d cyc=%0d want src=%0d cyc=%0d",
                     n, a_src, s_cyc, (n / 2) % NR, 2 + (n / 2) * 3 + n % 2);
          end
        end
        n++;
      end
    end
    total++;
    if (n != 24) begin
      bad++;
      $display("FAIL fair_count got=%0d want=24", n);
    end
  endtask

  task automatic test_truncation();
    logic [DW+SW:0] want [8];
    int n;
    want[0] = {2'd1, 1'b0, 10'h101}; want[1] = {2'd1, 1'b0, 10'h102};
    want[2] = {2'd1, 1'b0, 10'h103}; want[3] = {2'd1, 1'b1, 10'h104};
    want[4] = {2'd3, 1'b0, 10'h301}; want[5] = {2'd3, 1'b1, 10'h302};
    want[6] = {2'd1, 1'b0, 10'h105}; want[7] = {2'd1, 1'b1, 10'h106};
    do_reset();
    for (int w = 1; w <= 6; w++) sq[1].push_back({1'(w == 6), DW'(12'h100 + w)});
    sq[3].push_back({1'b0, 10'h301});
    sq[3].push_back({1'b1, 10'h302});
    n = 0;
    for (int c = 0; c < 30; c++) begin
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL trunc_model cyc=%0d got=%h want=%h", s_cyc, act_vec, exp_vec);
      end
      if (a_beat) begin
        total++;
        if (n >= 8 || {a_src, a_last, a_data} !== want[n % 8]) begin
          bad++;
          $display("FAIL trunc_beat n=%0d got=%h want=%h", n, {a_src, a_last, a_data}, want[n % 8]);
        end
        n++;
      end
    end
    total++;
    if (n != 8) begin
      bad++;
      $display("FAIL trunc_count got=%0d want=8", n);
    end
  endtask

  task automatic test_backpressure();
    logic [DW-1:0] prev;
    int n;
    do_reset();
    for (int w = 1; w <= 4; w++) sq[0].push_back({1'(w == 4), DW'(12'h010 + w)});
    n = 0;
    prev = '0;
    for (int c = 0; c < 14; c++) begin
      rdy_drv = !(c >= 3 && c <= 5);
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL bp_model cyc=%0d got=%h want=%h", s_cyc, act_vec, exp_vec);
      end
      if (s_cyc >= 3 && s_cyc <= 5) begin
        total++;
        if (a_reqrdy !== '0 || !a_vld || a_data !== 10'h012 || a_src !== 2'd0) begin
          bad++;
          $display("FAIL bp_stall cyc=%0d got rdy=%b vld=%b data=%h src=%0d want 0/1/012/0",
                   s_cyc, a_reqrdy, a_vld, a_data, a_src);
        end
        if (s_cyc > 3) begin
          total++;
          if (a_data !== prev) begin
            bad++;
            $display("FAIL bp_hold cyc=%0d got=%h want=%h", s_cyc, a_data, prev);
          end
        end
      end
      prev = a_data;
      if (a_beat) begin
        total++;
        if (a_data !== DW'(12'h011 + n)) begin
          bad++;
          $display("FAIL bp_seq n=%0d got=%h want=%h", n, a_data, 12'h011 + n);
        end
        n++;
      end
    end
    rdy_drv = 1'b1;
    total++;
    if (n != 4) begin
      bad++;
      $display("FAIL bp_count got=%0d want=4", n);
    end
  endtask

  task automatic test_gap_reset();
    logic seen;
    do_reset();
    for (int w = 1; w <= 4; w++) sq[0].push_back({1'(w == 4), DW'(12'h020 + w)});
    sq[1].push_back({1'b0, 10'h031});
    sq[1].push_back({1'b1, 10'h032});
    for (int c = 0; c < 6; c++) begin
      gap[0] = (c == 2 || c == 3);
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL gap_model cyc=%0d got=%h want=%h", s_cyc, act_vec, exp_vec);
      end
      if (s_cyc >= 1) begin
        total++;
        if (!a_busy || a_reqrdy[1] || (a_vld && a_src == 2'd1)) begin
          bad++;
          $display("FAIL gap_hold cyc=%0d got busy=%b rdy=%b src=%0d want grant kept on 0",
                   s_cyc, a_busy, a_reqrdy, a_src);
        end
      end
    end
    clear_queues();
    rst_drv = 1'b1;
    step();
    total++;
    if (act_vec !== '0) begin
      bad++;
      $display("FAIL gap_reset got=%h want=0", act_vec);
    end
    rst_drv = 1'b0;
    sq[3].push_back({1'b1, 10'h3c0});
    sq[1].push_back({1'b1, 10'h1c0});
    seen = 0;
    for (int c = 0; c < 10 && !seen; c++) begin
      step();
      if (a_beat) begin
        seen = 1;
        total++;
        if (a_src !== 2'd1 || a_data !== 10'h1c0) begin
          bad++;
          $display("FAIL gap_after_reset got src=%0d data=%h want src=1 data=1c0", a_src, a_data);
        end
      end
    end
    if (!seen) begin
      total++; bad++;
      $display("FAIL gap_after_reset got no beat want src=1");
    end
  endtask

  task automatic test_random();
    logic drained;
    int   len;
    do_reset();
    for (int i = 0; i < NR; i++)
      for (int b = 0; b < $urandom_range(2, 4); b++) begin
        len = $urandom_range(1, 7);
        for (int w = 0; w < len; w++) sq[i].push_back({1'(w == len - 1), DW'($urandom)});
      end
    drained = 0;
    for (int c = 0; c < 3000 && !drained; c++) begin
      gap = NR'($urandom) & NR'($urandom);
      rdy_drv = ($urandom % 4) != 0;
      step();
      total++;
      if (act_vec !== exp_vec) begin
        bad++;
        $display("FAIL rand_model cyc=%0d got=%h want=%h", s_cyc, act_vec, exp_vec);
      end
      drained = !m_busy && !m_vld;
      for (int i = 0; i < NR; i++) if (sq[i].size() > 0) drained = 0;
    end
    total++;
    if (!drained) begin
      bad++;
      $display("FAIL rand_drain got pending words want all delivered");
    end
    gap = '0;
    rdy_drv = 1'b1;
  endtask

  initial begin
    m_reset();
    cyc = 0;
    test_reset();
    test_single();
    test_fairness();
    test_truncation();
    test_backpressure();
    test_gap_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/writer_arb.md
# writer_arb

Round-robin arbiter that shares the single writer datapath input port (DWIDTH-bit data, valid/ready) between NREQ independent requesters. Each requester presents bursts of words delimited by `req_last`. The arbiter grants one requester at a time, holds the grant for at most BURST words, and forwards words through a single registered output stage. The output stage drives the writer with the source index attached. It sits directly in front of the writer, so the existing writer environment can be reused with its input agent driving one requester port.

## Interface
- `DWIDTH`, 10: data word width, equal to the writer data width.
- `NREQ`, 4: number of requesters, 2..16.
- `SWIDTH`, 2: source index width, clog2(NREQ).
- `BURST`, 4: maximum words per grant, 1..15.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `req_vld` in NREQ: per-requester word valid.
- `req_data` in NREQ*DWIDTH: requester i's data is in slice [i*DWIDTH +: DWIDTH].
- `req_last` in NREQ: word is the last of the requester's burst.
- `req_rdy` out NREQ: per-requester accept. At most one bit is high.
- `wr_vld` out 1: output word valid, registered.
- `wr_data` out DWIDTH: output word, registered.
- `wr_src` out SWIDTH: index of the requester that sourced the word.
- `wr_last` out 1: last word of the grant.
- `wr_rdy` in 1: writer accepts the word.
- `busy` out 1: FSM is in XFER.

## Operation
- FSM states:
  - IDLE: no grant held.
  - XFER: grant held by `gnt` (SWIDTH bits).
- Round-robin pointer `ptr` (SWIDTH bits), reset to 0.
- IDLE transitions:
  - If any `req_vld` is set, pick the first set bit searching ptr, ptr+1, … modulo NREQ.
  - Latch the winner into `gnt`, clear `cnt`, go to XFER.
  - No word is accepted in the IDLE cycle.
- Accept condition: in XFER, `req_rdy[gnt] = !wr_vld || wr_rdy`. All other `req_rdy` bits are 0. In IDLE, `req_rdy` = 0.
- A word is accepted when `req_vld[gnt] && req_rdy[gnt]`. On acceptance:
  - `wr_data` ← slice of `gnt`; `wr_src` ← `gnt`; `wr_vld` ← 1.
  - `wr_last` ← `req_last[gnt] || (cnt == BURST-1)`.
  - `cnt` ← `cnt+1` (width clog2(BURST+1)).
- End of grant: when the accepted word has `wr_last` set:
  - FSM → IDLE.
  - `ptr` ← `gnt+1` modulo NREQ. Wrap: gnt = NREQ-1 gives ptr = 0.
- Output drain: if `wr_vld && wr_rdy` and no new word is accepted, `wr_vld` ← 0. Hold `wr_data`, `wr_src` and `wr_last` while `wr_vld && !wr_rdy`.
- Granted requester drops `req_vld` mid-burst: the grant is held, `cnt` is frozen, and no timeout applies. Other requesters are not serviced until `req_last` or BURST is reached.
- A burst truncated at BURST continues in that requester's next grant. The arbiter does not track `req_last` across grants.
- Reset, asynchronous, any time:
  - State = IDLE, `ptr` = 0, `gnt` = 0, `cnt` = 0.
  - `wr_vld` = 0, `wr_data` = 0, `wr_src` = 0, `wr_last` = 0.
  - `req_rdy` = 0, `busy` = 0.
  - An in-flight word is discarded.

## Timing
- Grant latency: `req_vld` high in IDLE at cycle 0 → XFER and `req_rdy` high in cycle 1. The first word is accepted at the end of cycle 1 and `wr_vld` is high in cycle 2.
- Datapath latency: 1 cycle from acceptance to `wr_*`.
- Full throughput within a grant: 1 word per cycle while `wr_rdy` = 1.
- One IDLE arbitration cycle between grants, so sustained maximum is BURST/(BURST+1).
- Backpressure: `wr_rdy` low with `wr_vld` high forces `req_rdy` low in the same cycle (combinational).
- Arbitration in IDLE overlaps draining of the last word of the previous grant.

## Test plan
- Single requester: after reset, req 2 sends 3 words 0x001, 0x002, 0x003 with last on the third, `wr_rdy` = 1.
  - `wr_data` 0x001..0x003 in cycles 2-4, `wr_src` = 2.
  - `wr_last` only on 0x003; `ptr` = 3 afterwards.
- Fairness: all 4 requesters hold `req_vld` continuously with 2-word bursts.
  - Grant order 0, 1, 2, 3, 0.
  - Exactly 2 `wr_vld` beats per grant, 1 idle cycle between grants.
- BURST truncation: req 1 sends 6 words with no `req_last` until word 6, req 3 also pending.
  - 4 words from src 1 with `wr_last` on the 4th.
  - Then src 3's burst, then the remaining 2 words from src 1.
- Backpressure: `wr_rdy` low for 3 cycles mid-burst.
  - `wr_data` and `wr_src` stable while stalled.
  - `req_rdy` low during the stall; no word lost or duplicated.
  - Sequence is intact after release.
- Gap and reset: granted req 0 drops `req_vld` for 2 cycles.
  - Grant is held, req 1 is not serviced.
  - Assert `rst` mid-burst: all outputs read 0 in the next sample.
  - First grant after reset goes to the lowest-indexed pending requester.
